// File: rtl/sd_sector_arbiter_pkg.sv
// sd_arb_pkg: shared constants and types for the SD sector arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sd_arb_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int SECTOR_LAST  = SECTOR_BYTES - 1;

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} arb_state_t;

  typedef logic [8:0] byte_cnt_t;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sd_sector_arbiter_if.sv
// sd_sector_arbiter_if: requester-side and SD-controller-side signals of the sector arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req until done; the controller paces bytes with its strobes.
interface sd_sector_arbiter_if #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 32
);

  // Requester side
  logic [NREQ-1:0]              req;
  logic [NREQ-1:0]              req_wr;
  logic [NREQ-1:0][ADDR_W-1:0]  req_addr;
  logic [NREQ-1:0]              gnt;
  logic [NREQ-1:0]              done;
  logic [NREQ-1:0][7:0]         wdata;
  logic [NREQ-1:0]              wtake;
  logic [7:0]                   rdata;
  logic [NREQ-1:0]              rvalid;

  // SD controller side
  logic                         sd_ready;
  logic [ADDR_W-1:0]            sd_address;
  logic                         sd_rd;
  logic                         sd_wr;
  logic [7:0]                   sd_din;
  logic [7:0]                   sd_dout;
  logic                         sd_byte_available;
  logic                         sd_ready_for_next_byte;

  // Arbiter view
  modport master (
    input  req, req_wr, req_addr, wdata,
    input  sd_ready, sd_dout, sd_byte_available, sd_ready_for_next_byte,
    output gnt, done, wtake, rdata, rvalid,
    output sd_address, sd_rd, sd_wr, sd_din
  );

  // Requesters plus controller view
  modport slave (
    output req, req_wr, req_addr, wdata,
    output sd_ready, sd_dout, sd_byte_available, sd_ready_for_next_byte,
    input  gnt, done, wtake, rdata, rvalid,
    input  sd_address, sd_rd, sd_wr, sd_din
  );

endinterface

// File: rtl/sd_sector_arbiter_rr_picker.sv
// rr_picker: round-robin winner among pending requests, searching from ptr+1 upward with wrap.
// Latency: combinational.
// Backpressure: none; the caller decides when to act on the pick.
module rr_picker #(
  parameter int NREQ  = 3,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Walk the requesters after the last winner; the last winner itself is checked last.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NREQ);
      if (!found && req[cand]) begin
        found        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/sd_sector_arbiter.sv
// sd_sector_arbiter: shares one SPI SD controller among NREQ sector requesters, round-robin, one 512-byte sector per grant.
// Latency: gnt one cycle after the IDLE decision; rvalid/wtake one cycle after each strobe rising edge; done one cycle after the 512th edge.
// Backpressure: byte pacing comes from the controller strobes only; requesters hold req until done. SD_ARB_STATS_EN adds stat_sectors/stat_clr.
module sd_sector_arbiter
  import sd_arb_pkg::*;
#(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  sd_sector_arbiter_if.master    bus
`ifdef SD_ARB_STATS_EN
  ,
  input  logic                   stat_clr,
  output logic [NREQ-1:0][15:0]  stat_sectors
`endif
);

  localparam int IDX_W = idx_width(NREQ);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q;          // last winner; also the index of the current owner
  logic             wr_q;
  byte_cnt_t        cnt_q;
  logic             avail_prev_q;
  logic             rfnb_prev_q;
  logic [NREQ-1:0]  pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             strobe_rise;
  logic             start;
  logic             last_edge;

  rr_picker #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  // Strobe edge of whichever direction is active, grant start and terminal-count detection
  always_comb begin
    strobe_rise = wr_q ? (bus.sd_ready_for_next_byte & ~rfnb_prev_q)
                       : (bus.sd_byte_available & ~avail_prev_q);
    start       = (state_q == IDLE) && (|bus.req) && bus.sd_ready;
    last_edge   = (state_q == XFER) && strobe_rise && (cnt_q == byte_cnt_t'(SECTOR_LAST));
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state decision
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)         state_d = ISSUE;
      ISSUE:   if (!bus.sd_ready) state_d = XFER;
      XFER:    if (last_edge)     state_d = DONE;
      DONE:                       state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Write byte follows the owner's wdata for the whole sector, quiet otherwise
  always_comb begin
    bus.sd_din = '0;
    if (state_q != IDLE && wr_q) bus.sd_din = bus.wdata[ptr_q];
  end

  // Grant latching, controller command, byte counting and per-byte pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q          <= IDX_W'(NREQ - 1);
      wr_q           <= 1'b0;
      cnt_q          <= '0;
      avail_prev_q   <= 1'b0;
      rfnb_prev_q    <= 1'b0;
      bus.gnt        <= '0;
      bus.done       <= '0;
      bus.wtake      <= '0;
      bus.rvalid     <= '0;
      bus.rdata      <= '0;
      bus.sd_address <= '0;
      bus.sd_rd      <= 1'b0;
      bus.sd_wr      <= 1'b0;
    end else begin
      avail_prev_q <= bus.sd_byte_available;
      rfnb_prev_q  <= bus.sd_ready_for_next_byte;
      bus.done     <= '0;
      bus.wtake    <= '0;
      bus.rvalid   <= '0;
      case (state_q)
        IDLE: begin
          if (start) begin
            bus.gnt        <= pick_oh;
            ptr_q          <= pick_idx;
            wr_q           <= bus.req_wr[pick_idx];
            // Sector aligned: low 9 address bits are dropped
            bus.sd_address <= bus.req_addr[pick_idx] & ~ADDR_W'(SECTOR_BYTES - 1);
            bus.sd_rd      <= ~bus.req_wr[pick_idx];
            bus.sd_wr      <= bus.req_wr[pick_idx];
          end
        end
        ISSUE: cnt_q <= '0;
        XFER: begin
          if (strobe_rise) begin
            cnt_q <= cnt_q + byte_cnt_t'(1);
            if (wr_q) begin
              bus.wtake[ptr_q] <= 1'b1;
            end else begin
              bus.rdata         <= bus.sd_dout;
              bus.rvalid[ptr_q] <= 1'b1;
            end
            if (last_edge) begin
              bus.sd_rd       <= 1'b0;
              bus.sd_wr       <= 1'b0;
              bus.done[ptr_q] <= 1'b1;
              bus.gnt         <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SD_ARB_STATS_EN
  // Completed-sector counters, saturating; a clear in the completion cycle wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_sectors <= '0;
    end else if (stat_clr) begin
      stat_sectors <= '0;
    end else if (state_q == DONE && stat_sectors[ptr_q] != 16'hFFFF) begin
      stat_sectors[ptr_q] <= stat_sectors[ptr_q] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// tb_sd_sector_arbiter: directed bench for the SD sector arbiter with a simple strobe-driven SD controller model.
// Latency: n/a.
// Backpressure: the controller model paces every byte with a 2-high/2-low strobe.
module tb_sd_sector_arbiter;

  logic clk;
  logic rst;

  sd_sector_arbiter_if #(.NREQ(3), .ADDR_W(32)) bus ();

`ifdef SD_ARB_STATS_EN
  logic            stat_clr;
  logic [2:0][15:0] stat_sectors;
  bit              clr_at_done;
`endif

  sd_sector_arbiter #(.NREQ(3), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus)
`ifdef SD_ARB_STATS_EN
    ,
    .stat_clr     (stat_clr),
    .stat_sectors (stat_sectors)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  int rv_cnt[3] = '{0, 0, 0};
  int wt_cnt[3] = '{0, 0, 0};
  int dn_cnt[3] = '{0, 0, 0};

  // Pulse counters, observed away from the active edge
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (bus.rvalid[i] === 1'b1) rv_cnt[i]++;
      if (bus.wtake[i]  === 1'b1) wt_cnt[i]++;
      if (bus.done[i]   === 1'b1) dn_cnt[i]++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Serve one grant for requester who: check grant/command, run nbytes strobes,
  // and on a full sector check the completion handshake.
  task automatic serve_sector(input int who, input bit is_wr, input logic [31:0] exp_addr,
                              input int nbytes, input bit rearm);
    int         waited;
    int         err_en, err_dat, err_pulse, err_done;
    int         rv0, wt0, dn0;
    logic [2:0] oh;
    logic [7:0] kb;
    waited = 0; err_en = 0; err_dat = 0; err_pulse = 0; err_done = 0;
    oh  = 3'b001 << who;
    rv0 = rv_cnt[who]; wt0 = wt_cnt[who]; dn0 = dn_cnt[who];
    while (bus.gnt == '0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("gnt_order_r%0d", who), bus.gnt, oh);
    if (bus.gnt != oh) return;
    check($sformatf("sd_address_r%0d", who), bus.sd_address, exp_addr);
    check($sformatf("cmd_at_gnt_r%0d", who), {bus.sd_rd, bus.sd_wr}, {~is_wr, is_wr});
    if (is_wr) check("first_wbyte_at_gnt", bus.sd_din, bus.wdata[who]);
    bus.sd_ready = 1'b0;
    for (int k = 0; k < nbytes; k++) begin
      kb = 8'(k);
      @(negedge clk);
      if ((is_wr ? bus.sd_wr : bus.sd_rd) !== 1'b1) err_en++;
      if (is_wr) begin
        bus.sd_ready_for_next_byte = 1'b1;
        if (bus.sd_din !== kb) err_dat++;
      end else begin
        bus.sd_dout           = kb;
        bus.sd_byte_available = 1'b1;
      end
      @(negedge clk);
      if (is_wr) begin
        if (bus.wtake !== oh) err_pulse++;
        bus.wdata[who] = bus.wdata[who] + 8'd1;
      end else begin
        if (bus.rvalid !== oh) err_pulse++;
        if (bus.rdata !== kb) err_dat++;
      end
      if (k == 511) begin
        check($sformatf("done_pulse_r%0d", who), bus.done, oh);
        check($sformatf("cmd_dropped_r%0d", who), {bus.sd_rd, bus.sd_wr}, 2'b00);
        check($sformatf("gnt_released_r%0d", who), bus.gnt, 3'b000);
        bus.req[who] = 1'b0;
`ifdef SD_ARB_STATS_EN
        if (clr_at_done) stat_clr = 1'b1;
`endif
      end else if (bus.done !== 3'b000) begin
        err_done++;
      end
      @(negedge clk);
      bus.sd_byte_available      = 1'b0;
      bus.sd_ready_for_next_byte = 1'b0;
      if (k == 511 && rearm) bus.req[who] = 1'b1;
`ifdef SD_ARB_STATS_EN
      stat_clr = 1'b0;
`endif
      @(negedge clk);
    end
    bus.sd_ready = 1'b1;
    check($sformatf("cmd_held_r%0d", who), err_en, 0);
    check($sformatf("byte_data_r%0d", who), err_dat, 0);
    check($sformatf("byte_pulse_r%0d", who), err_pulse, 0);
    check($sformatf("early_done_r%0d", who), err_done, 0);
    if (is_wr) check($sformatf("wtake_total_r%0d", who), wt_cnt[who] - wt0, nbytes);
    else       check($sformatf("rvalid_total_r%0d", who), rv_cnt[who] - rv0, nbytes);
    check($sformatf("done_total_r%0d", who), dn_cnt[who] - dn0, (nbytes == 512) ? 1 : 0);
  endtask

  // Runaway guard
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_gnt;
    rst                        = 1'b0;
    bus.req                    = '0;
    bus.req_wr                 = '0;
    bus.req_addr               = '0;
    bus.wdata                  = '0;
    bus.sd_ready               = 1'b1;
    bus.sd_dout                = '0;
    bus.sd_byte_available      = 1'b0;
    bus.sd_ready_for_next_byte = 1'b0;
`ifdef SD_ARB_STATS_EN
    stat_clr    = 1'b0;
    clr_at_done = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_gnt", bus.gnt, 3'b000);
    check("rst_pulses", {bus.done, bus.wtake, bus.rvalid}, 9'h000);
    check("rst_cmd", {bus.sd_rd, bus.sd_wr}, 2'b00);
    check("rst_addr", bus.sd_address, 32'h0);
    check("rst_rdata", bus.rdata, 8'h00);
    check("rst_sd_din", bus.sd_din, 8'h00);
    rst = 1'b1;
    @(negedge clk);

    // Contention: all three read together -> 0,1,2; requester 0 re-arms after its
    // done and must yield to 1 and then 2 before being served again.
    for (int i = 0; i < 3; i++) bus.req_addr[i] = 32'h1000 * (i + 1);
    bus.req = 3'b111;
    serve_sector(0, 1'b0, 32'h0000_1000, 512, 1'b1);
    serve_sector(1, 1'b0, 32'h0000_2000, 512, 1'b0);
    serve_sector(2, 1'b0, 32'h0000_3000, 512, 1'b0);
    serve_sector(0, 1'b0, 32'h0000_1000, 512, 1'b0);

    // Single read on requester 1
    bus.req_addr[1] = 32'h0000_0400;
    bus.req[1]      = 1'b1;
    serve_sector(1, 1'b0, 32'h0000_0400, 512, 1'b0);

    // Single write on requester 0, bytes 0x00..0xFF twice
    bus.req_addr[0] = 32'h2000_0200;
    bus.req_wr[0]   = 1'b1;
    bus.wdata[0]    = 8'h00;
    bus.req[0]      = 1'b1;
    serve_sector(0, 1'b1, 32'h2000_0200, 512, 1'b0);
    bus.req_wr[0]   = 1'b0;

    // Controller busy in IDLE: no grant; then a misaligned address is sector aligned
    bus.sd_ready    = 1'b0;
    bus.req_addr[2] = 32'h0000_0123;
    bus.req[2]      = 1'b1;
    busy_gnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.gnt !== 3'b000) busy_gnt++;
    end
    check("no_gnt_while_busy", busy_gnt, 0);
    bus.sd_ready = 1'b1;
    serve_sector(2, 1'b0, 32'h0000_0000, 512, 1'b0);

    // Abort a read at byte 300 with an asynchronous reset
    bus.req_addr[1] = 32'h0000_0400;
    bus.req[1]      = 1'b1;
    serve_sector(1, 1'b0, 32'h0000_0400, 300, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("abort_gnt", bus.gnt, 3'b000);
    check("abort_cmd", {bus.sd_rd, bus.sd_wr}, 2'b00);
    check("abort_addr", bus.sd_address, 32'h0);
    check("abort_rdata", bus.rdata, 8'h00);
    check("abort_pulses", {bus.done, bus.wtake, bus.rvalid}, 9'h000);
    bus.req                   = '0;
    bus.sd_byte_available     = 1'b0;
    bus.sd_ready              = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_abort_idle", bus.gnt, 3'b000);
    bus.req[1] = 1'b1;
    serve_sector(1, 1'b0, 32'h0000_0400, 512, 1'b0);

`ifdef SD_ARB_STATS_EN
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    check("stat_cleared", stat_sectors, 48'h0);
    for (int s = 0; s < 3; s++) begin
      bus.req[2] = 1'b1;
      serve_sector(2, 1'b0, 32'h0000_0000, 512, 1'b0);
    end
    check("stat_r2_three", stat_sectors[2], 16'd3);
    check("stat_r0_zero", stat_sectors[0], 16'd0);
    clr_at_done = 1'b1;
    bus.req[2]  = 1'b1;
    serve_sector(2, 1'b0, 32'h0000_0000, 512, 1'b0);
    clr_at_done = 1'b0;
    check("stat_clr_beats_inc", stat_sectors[2], 16'd0);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sd_sector_arbiter.md
Name: sd_sector_arbiter

Overview:
- Shares the single SPI sd_controller between N sector-level requesters (store, load and mix pipelines).
- Each requester asks for one 512-byte sector read or write.
- The arbiter grants round-robin, drives the controller's address/rd/wr, and counts rising edges of byte_available / ready_for_next_byte.
- It routes bytes to and from the granted requester, then pulses done.

Parameters:
- NREQ, 3, number of requesters (2..8).
- ADDR_W, 32, SD byte-address width.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester sector request level; held until done.
- req_wr  in  NREQ  1 = write sector, 0 = read sector; sampled at grant.
- req_addr  in  NREQ*ADDR_W  sector byte address per requester; sampled at grant.
- gnt  out  NREQ  one-hot; high from grant until done.
- done  out  NREQ  one-cycle pulse when the granted sector completes.
- wdata  in  NREQ*8  write byte per requester; sampled on wtake.
- wtake  out  NREQ  one-cycle pulse: granted writer's current byte consumed; present next byte.
- rdata  out  8  read byte, shared bus.
- rvalid  out  NREQ  one-cycle pulse: rdata valid for granted reader.
- sd_ready  in  1  controller idle.
- sd_address  out  ADDR_W  controller address.
- sd_rd  out  1  controller read enable.
- sd_wr  out  1  controller write enable.
- sd_din  out  8  controller write byte.
- sd_dout  in  8  controller read byte.
- sd_byte_available  in  1  controller read strobe (level, multi-cycle).
- sd_ready_for_next_byte  in  1  controller write strobe (level, multi-cycle).

Behaviour:
- Reset (rst low, async): state IDLE. gnt, done, wtake, rvalid, sd_rd, sd_wr = 0. sd_address, sd_din, rdata = 0. RR pointer = NREQ-1. Both edge-detect prev registers = 0. Byte counter = 0.
- An assertion mid-sector aborts immediately. No done pulse after release.

States:
- IDLE: if any req and sd_ready, pick a winner in round-robin order starting at pointer+1. Next edge: gnt[w]=1, latch req_wr[w] and req_addr[w] with bits [8:0] forced to 0, pointer=w, go to ISSUE. No req: stay.
- ISSUE: assert sd_rd or sd_wr. Stay until sd_ready=0, then go to XFER. Counter=0.
- XFER, read: on each 0->1 of sd_byte_available, rdata<=sd_dout and rvalid[w] pulses on the following cycle. Counter increments.
- XFER, write: sd_din is continuously wdata[w]. On each 0->1 of sd_ready_for_next_byte, wtake[w] pulses for one cycle and the counter increments.
- On the 512th edge: drop sd_rd/sd_wr the same edge the counter reaches 511, then go to DONE.
- DONE: done[w]=1 and gnt<=0 for one cycle, then go to IDLE.
- Minimum gap between consecutive grants: 2 cycles (DONE + IDLE decision).

Rules:
- Counter is 9 bits plus terminal-count compare at 511. No wrap is visible outside.
- The first write byte must be valid on wdata[w] from the grant cycle.
- A requester dropping req mid-sector is ignored. The sector completes and done still pulses.
- req, req_wr, req_addr changes after grant are ignored.
- Simultaneous requests: only the RR winner is granted. The others wait with no starvation; each waits at most NREQ-1 sectors.
- A requester that re-asserts req the cycle after done is lower priority than any other pending requester.
- If sd_ready is low in IDLE, no grant is made.

Optional Feature:
- Macro: SD_ARB_STATS_EN.
- Defined: adds output stat_sectors (NREQ*16), per-requester count of completed sectors.
  - Increments in DONE; saturates at 16'hFFFF.
  - Reset to 0 by rst and by new input stat_clr (1, synchronous pulse).
  - stat_clr has priority over a same-cycle increment.
- Undefined: those ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package sd_arb_pkg:
  - SECTOR_BYTES = 512, SECTOR_LAST = 511.
  - typedef enum arb_state_t {IDLE, ISSUE, XFER, DONE}.
  - typedef logic [8:0] byte_cnt_t.
- Sub-module rr_picker (NREQ): combinational. Inputs req and pointer; outputs one-hot winner and its index. Instantiated once.

Test Plan:
- Single read: req[1]=1 (read), addr 0x0000_0400, sd model returns bytes 0..255,0..255. Expect:
  - sd_address=0x400, sd_rd high through the 512th strobe.
  - Exactly 512 rvalid[1] pulses with matching rdata.
  - One done[1].
- Single write: req[0]=1 (write), addr 0x2000_0200, wdata incrementing on wtake. Expect sd model captures 0x00..0xFF twice, 512 wtake[0] pulses, sd_wr drops after the 512th.
- Contention: req=3'b111 together, all reads. Expect grant order 0,1,2. Then, with req[0] re-asserted after its done and req[2] still pending, expect 2 before 0.
- Misaligned address 0x0000_0123 -> sd_address=0x0000_0000. Held sd_ready=0 in IDLE with req pending -> no gnt until sd_ready=1.
- Abort: rst low at byte 300 of a read. Expect all outputs 0 asynchronously. After release, a new req gets gnt with counter restarted (512 fresh rvalid).
- With SD_ARB_STATS_EN: 3 sectors for requester 2 -> stat_sectors[2]=3. stat_clr in the same cycle as done -> 0.
